// File: rtl/pic_ctrl.sv
// pic_ctrl: Wishbone programmable interrupt controller with pending/mask/edge/ISR registers and vectored acknowledge.
// Define PIC_IRQ_SYNC_EN to add a 2-flop synchroniser on every request line.
module pic_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter logic [31:0] RESET_MASK = 32'hFFFF_FFFF
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic               we_i,
  input  logic [3:0]         sel_i,
  input  logic [31:0]        adr_i,
  input  logic [31:0]        dat_i,
  output logic [31:0]        dat_o,
  output logic               ack_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               int_o
);
  localparam int N = NUM_IRQ;
  logic [N-1:0] pending, mask, edge_mode, isr, irq_q, irq_s;
  logic [N-1:0] cand, clr, rise, pend_n, best_bit, eoi_bits;
  logic [4:0] best;
  logic found, stop, access, wr, rd, vec_ack;
  logic [2:0] off;
  logic [31:0] rdata;
  logic unused;
  assign unused = ^{sel_i, adr_i, dat_i};
`ifdef PIC_IRQ_SYNC_EN
  logic [N-1:0] sync1, sync2;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_i;
      sync2 <= sync1;
    end
  assign irq_s = sync2;
`else
  assign irq_s = irq_i;
`endif
  assign access = cyc_i & stb_i & ~ack_o;
  assign wr = access & we_i;
  assign rd = access & ~we_i;
  assign off = adr_i[4:2];
  assign cand = pending & ~mask;
  // Scan upward; the first ISR bit blocks everything at or above it, so found means eligible.
  always_comb begin
    found = 1'b0;
    best = '0;
    stop = 1'b0;
    for (int i = 0; i < N; i++) begin
      stop = stop | isr[i];
      if (!stop && cand[i]) begin
        found = 1'b1;
        best = 5'(i);
      end
      stop = stop | cand[i];
    end
  end
  assign best_bit = found ? N'(1) << best : '0;
  assign vec_ack = rd && off == 3'd2 && found;
  assign eoi_bits = (wr && off == 3'd3) ? N'(1) << dat_i[4:0] : '0;
  assign clr = ((wr && off == 3'd0) ? dat_i[N-1:0] : '0) | (vec_ack ? best_bit : '0);
  assign rise = irq_s & ~irq_q;
  // Rise is OR-ed after the clear so a new edge beats a same-cycle W1C.
  assign pend_n = (edge_mode & ((pending & ~clr) | rise)) | (~edge_mode & irq_s);
  assign rdata = off == 3'd0 ? 32'(pending) :
                 off == 3'd1 ? 32'(mask) :
                 off == 3'd2 ? (found ? {1'b1, 26'b0, best} : 32'h0) :
                 off == 3'd4 ? 32'(edge_mode) :
                 off == 3'd5 ? 32'(isr) : 32'h0;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      pending <= '0;
      mask <= RESET_MASK[N-1:0];
      edge_mode <= '0;
      isr <= '0;
      irq_q <= '0;
      dat_o <= '0;
      ack_o <= 1'b0;
      int_o <= 1'b0;
    end else begin
      irq_q <= irq_s;
      pending <= pend_n;
      isr <= (isr | (vec_ack ? best_bit : '0)) & ~eoi_bits;
      int_o <= found;
      ack_o <= access;
      if (access) dat_o <= rdata;
      if (wr && off == 3'd1) mask <= dat_i[N-1:0];
      if (wr && off == 3'd4) edge_mode <= dat_i[N-1:0];
    end
endmodule
